// File: rtl/line_cmd_queue_if.sv
// line_cmd_queue_if: host command port and drawer port of the line command queue.
interface line_cmd_queue_if #(parameter int WIDTH = 13);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [2:0]       cmd_rgb;
    logic             flush;
    logic             start;
    logic [WIDTH-1:0] x0, y0, x1, y1;
    logic             red_out, green_out, blue_out;
    logic             sys_finish;
    logic             busy;
    logic             empty;
    logic [15:0]      lines_done;
    logic             cmd_err;
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, flush, sys_finish,
        input  cmd_ready, start, x0, y0, x1, y1, red_out, green_out, blue_out, busy, empty,
               lines_done, cmd_err
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, flush, sys_finish,
        output cmd_ready, start, x0, y0, x1, y1, red_out, green_out, blue_out, busy, empty,
               lines_done, cmd_err
    );
endinterface

// File: rtl/line_cmd_queue.sv
// line_cmd_queue: FIFO of line commands issued one at a time to the drawer.
// Define LINE_CMD_CLIP_CHECK_EN to reject commands with endpoints outside XMAX x YMAX.
module line_cmd_queue #(
    parameter int WIDTH      = 13,
    parameter int DEPTH_LOG2 = 2,
    parameter int XMAX       = 320,
    parameter int YMAX       = 240
) (
    input logic clk,
    input logic reset,
    line_cmd_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = 4 * WIDTH + 3;
`ifdef LINE_CMD_CLIP_CHECK_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ISSUE, DRAW, RELEASE} state_t;
    state_t state, state_nx;
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [15:0] count;
    logic full, accept, in_range, ok, push, pop, err_q;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
    assign in_range = bus.cmd_x0 < WIDTH'(XMAX) && bus.cmd_x1 < WIDTH'(XMAX) &&
                      bus.cmd_y0 < WIDTH'(YMAX) && bus.cmd_y1 < WIDTH'(YMAX);
    assign ok = !CLIP || in_range;
    assign accept = bus.cmd_valid && !full;
    // A flush discards any push landing in the same cycle.
    assign push = accept && ok && !bus.flush;
    assign pop = state == IDLE && !bus.empty && !bus.flush;
    assign bus.empty = wr_ptr == rd_ptr;
    assign bus.cmd_ready = !full;
    assign bus.lines_done = count;
    assign bus.cmd_err = err_q;
    assign {bus.red_out, bus.green_out, bus.blue_out, bus.x0, bus.y0, bus.x1, bus.y1} = head;
    always_comb begin
        state_nx = state == IDLE  ? (pop ? ISSUE : IDLE) :
                   state == ISSUE ? DRAW :
                   state == DRAW  ? (bus.sys_finish ? RELEASE : DRAW) :
                                    (bus.sys_finish ? RELEASE : IDLE);
        bus.start = state == ISSUE;
        bus.busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= accept && !ok;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (bus.flush) rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pop) head <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            if (state == DRAW && bus.sys_finish && count != 16'hFFFF) count <= count + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.cmd_rgb, bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1};
    end
endmodule

// File: tb/tb_line_cmd_queue.sv
// tb_line_cmd_queue: directed, table-driven bench for line_cmd_queue.
module tb_line_cmd_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    line_cmd_queue_if #(.WIDTH(13)) bus();
    line_cmd_queue #(.WIDTH(13), .DEPTH_LOG2(2), .XMAX(320), .YMAX(240)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [12:0] x0, y0, x1, y1;
        logic [2:0]  rgb;
        logic        er, eg, eb;
    } vec_t;
    vec_t vec [15];

    logic [54:0] issued [$];
    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    int dbl = 0;
    logic prev_start = 1'b0;

    // Log every start pulse with the operands presented alongside it.
    always @(negedge clk) begin
        if (!reset) begin
            issued.delete();
            err_cnt = 0;
            dbl = 0;
            prev_start = 1'b0;
        end else begin
            if (bus.start) begin
                issued.push_back({bus.red_out, bus.green_out, bus.blue_out, bus.x0, bus.y0, bus.x1, bus.y1});
                if (prev_start) dbl++;
            end
            if (bus.cmd_err) err_cnt++;
            prev_start = bus.start;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int i);
        bus.cmd_x0 = vec[i].x0;
        bus.cmd_y0 = vec[i].y0;
        bus.cmd_x1 = vec[i].x1;
        bus.cmd_y1 = vec[i].y1;
        bus.cmd_rgb = vec[i].rgb;
    endtask

    task automatic push(input int i);
        set_cmd(i);
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (bus.cmd_ready) begin
                step();
                return;
            end
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: entry %0d got no handshake, expected one within 100 cycles", i);
    endtask

    task automatic wait_issue(input int n);
        for (int k = 0; k < 200; k++) begin
            if (issued.size() >= n) begin
                step();
                return;
            end
            step();
        end
        n_cmp++;
        n_err++;
        $display("FAIL issue_timeout: got %0d starts expected %0d", issued.size(), n);
    endtask

    task automatic finish_line();
        bus.sys_finish = 1'b1;
        step();
        bus.sys_finish = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic check_live(input string name, input int i);
        check({name, "_x0"}, 32'(bus.x0), 32'(vec[i].x0));
        check({name, "_y0"}, 32'(bus.y0), 32'(vec[i].y0));
        check({name, "_x1"}, 32'(bus.x1), 32'(vec[i].x1));
        check({name, "_y1"}, 32'(bus.y1), 32'(vec[i].y1));
        check({name, "_red"}, 32'(bus.red_out), 32'(vec[i].er));
        check({name, "_green"}, 32'(bus.green_out), 32'(vec[i].eg));
        check({name, "_blue"}, 32'(bus.blue_out), 32'(vec[i].eb));
    endtask

    task automatic check_rec(input string name, input int q, input int i);
        logic [54:0] r;
        if (q >= issued.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d starts expected more than %0d", name, issued.size(), q);
            return;
        end
        r = issued[q];
        check({name, "_x0"}, 32'(r[51:39]), 32'(vec[i].x0));
        check({name, "_y0"}, 32'(r[38:26]), 32'(vec[i].y0));
        check({name, "_x1"}, 32'(r[25:13]), 32'(vec[i].x1));
        check({name, "_y1"}, 32'(r[12:0]), 32'(vec[i].y1));
        check({name, "_rgb"}, 32'(r[54:52]), 32'({vec[i].er, vec[i].eg, vec[i].eb}));
    endtask

    initial begin
        vec[0]  = '{13'd10,  13'd20,  13'd100, 13'd50,  3'b101, 1'b1, 1'b0, 1'b1};
        vec[1]  = '{13'd0,   13'd0,   13'd319, 13'd239, 3'b111, 1'b1, 1'b1, 1'b1};
        vec[2]  = '{13'd5,   13'd6,   13'd7,   13'd8,   3'b001, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{13'd100, 13'd1,   13'd2,   13'd200, 3'b010, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{13'd319, 13'd239, 13'd0,   13'd0,   3'b100, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{13'd33,  13'd44,  13'd55,  13'd66,  3'b011, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{13'd1,   13'd2,   13'd3,   13'd4,   3'b110, 1'b1, 1'b1, 1'b0};
        vec[7]  = '{13'd12,  13'd34,  13'd56,  13'd78,  3'b111, 1'b1, 1'b1, 1'b1};
        vec[8]  = '{13'd200, 13'd100, 13'd50,  13'd25,  3'b000, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{13'd9,   13'd9,   13'd90,  13'd90,  3'b101, 1'b1, 1'b0, 1'b1};
        vec[10] = '{13'd11,  13'd22,  13'd33,  13'd44,  3'b010, 1'b0, 1'b1, 1'b0};
        vec[11] = '{13'd1,   13'd1,   13'd1,   13'd1,   3'b011, 1'b0, 1'b1, 1'b1};
        vec[12] = '{13'd2,   13'd3,   13'd4,   13'd5,   3'b100, 1'b1, 1'b0, 1'b0};
        vec[13] = '{13'd150, 13'd120, 13'd160, 13'd130, 3'b001, 1'b0, 1'b0, 1'b1};
        vec[14] = '{13'd10,  13'd10,  13'd320, 13'd10,  3'b111, 1'b1, 1'b1, 1'b1};
        bus.cmd_valid = 1'b0;
        bus.flush = 1'b0;
        bus.sys_finish = 1'b0;
        set_cmd(0);
        step();
        step();
        check("rst_start", 32'(bus.start), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_lines", 32'(bus.lines_done), 0);
        check("rst_x0", 32'(bus.x0), 0);
        check("rst_y1", 32'(bus.y1), 0);
        check("rst_red", 32'(bus.red_out), 0);
        check("rst_err", 32'(bus.cmd_err), 0);
        reset = 1'b1;
        step();

        // Single command: start exactly one cycle, two cycles after the push edge.
        set_cmd(0);
        bus.cmd_valid = 1'b1;
        check("t1_ready", 32'(bus.cmd_ready), 1);
        step();
        bus.cmd_valid = 1'b0;
        check("t1_start_n", 32'(bus.start), 0);
        check("t1_empty_n", 32'(bus.empty), 0);
        step();
        check("t1_start_n1", 32'(bus.start), 1);
        check_live("t1", 0);
        step();
        check("t1_start_off", 32'(bus.start), 0);
        check("t1_busy", 32'(bus.busy), 1);
        repeat (40) step();
        check("t1_busy_wait", 32'(bus.busy), 1);
        check("t1_lines_wait", 32'(bus.lines_done), 0);
        bus.sys_finish = 1'b1;
        step();
        bus.sys_finish = 1'b0;
        check("t1_lines", 32'(bus.lines_done), 1);
        step();
        check("t1_idle", 32'(bus.busy), 0);
        check("t1_starts", 32'(issued.size()), 1);
        check("t1_single_cycle", 32'(dbl), 0);

        // Full and backpressure.
        do_reset();
        for (int i = 1; i <= 5; i++) push(i);
        check("t2_full_ready", 32'(bus.cmd_ready), 0);
        check("t2_full_empty", 32'(bus.empty), 0);
        check("t2_inflight", 32'(issued.size()), 1);
        set_cmd(6);
        step();
        step();
        check("t2_sixth_waits", 32'(bus.cmd_ready), 0);
        finish_line();
        push(6);
        bus.cmd_valid = 1'b0;
        for (int n = 2; n <= 6; n++) begin
            wait_issue(n);
            finish_line();
        end
        step();
        check("t2_lines", 32'(bus.lines_done), 6);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_empty", 32'(bus.empty), 1);
        check("t2_ready", 32'(bus.cmd_ready), 1);
        check("t2_starts", 32'(issued.size()), 6);
        check("t2_single_cycle", 32'(dbl), 0);
        for (int i = 0; i < 6; i++) check_rec($sformatf("t2_order%0d", i), i, i + 1);

        // Level-style finish must not complete the next line early.
        do_reset();
        push(7);
        push(8);
        bus.cmd_valid = 1'b0;
        wait_issue(1);
        bus.sys_finish = 1'b1;
        repeat (10) step();
        check("t3_no_early_start", 32'(issued.size()), 1);
        check("t3_lines_held", 32'(bus.lines_done), 1);
        check("t3_busy_held", 32'(bus.busy), 1);
        bus.sys_finish = 1'b0;
        wait_issue(2);
        check("t3_lines_second", 32'(bus.lines_done), 1);
        finish_line();
        step();
        check("t3_lines", 32'(bus.lines_done), 2);
        check("t3_busy", 32'(bus.busy), 0);
        check_rec("t3_first", 0, 7);
        check_rec("t3_second", 1, 8);

        // Flush while a line is in flight.
        do_reset();
        for (int i = 9; i <= 12; i++) push(i);
        bus.cmd_valid = 1'b0;
        wait_issue(1);
        check("t4_pre_empty", 32'(bus.empty), 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t4_empty", 32'(bus.empty), 1);
        check("t4_busy", 32'(bus.busy), 1);
        check_live("t4_inflight", 9);
        repeat (3) step();
        check("t4_no_issue", 32'(issued.size()), 1);
        finish_line();
        step();
        check("t4_idle", 32'(bus.busy), 0);
        check("t4_lines", 32'(bus.lines_done), 1);
        check("t4_starts", 32'(issued.size()), 1);
        check("t4_empty_end", 32'(bus.empty), 1);

        // Asynchronous reset in the middle of DRAW.
        push(13);
        bus.cmd_valid = 1'b0;
        wait_issue(2);
        check("t5_busy_pre", 32'(bus.busy), 1);
        check("t5_lines_pre", 32'(bus.lines_done), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_start", 32'(bus.start), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_empty", 32'(bus.empty), 1);
        check("t5_lines", 32'(bus.lines_done), 0);
        check("t5_x0", 32'(bus.x0), 0);
        check("t5_ready", 32'(bus.cmd_ready), 1);
        step();
        reset = 1'b1;
        step();

`ifdef LINE_CMD_CLIP_CHECK_EN
        push(14);
        check("t6_err_pulse", 32'(bus.cmd_err), 1);
        push(13);
        bus.cmd_valid = 1'b0;
        check("t6_err_clear", 32'(bus.cmd_err), 0);
        wait_issue(1);
        finish_line();
        step();
        check("t6_err_count", 32'(err_cnt), 1);
        check("t6_starts", 32'(issued.size()), 1);
        check("t6_lines", 32'(bus.lines_done), 1);
        check_rec("t6_valid", 0, 13);
`else
        check("t6_err_never", 32'(err_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
